// File: rtl/oam_dma_arbiter_pkg.sv
// Shared CPU defines: DMA state encoding, register addresses and state helpers.
package oam_dma_arbiter_pkg;

  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR     = 16'h2004;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PEND  = 3'd1,
    ST_ALIGN = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } dma_state_e;

  // True in the states where the DMA engine owns the bus.
  function automatic logic is_dma_state(input dma_state_e s);
    return (s == ST_ALIGN) || (s == ST_READ) || (s == ST_WRITE);
  endfunction

  // A CPU bus cycle that writes the DMA trigger register.
  function automatic logic is_trigger(input logic [15:0] addr, input logic rw);
    return (rw == 1'b0) && (addr == DMA_TRIGGER_ADDR);
  endfunction

endpackage

// File: rtl/oam_dma_arbiter.sv
// OAM DMA engine: halts the CPU and copies page {page,00..FF} to OAMDATA,
// one byte per get/put cycle pair. The bus mux is inline.
module oam_dma_arbiter
  import oam_dma_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             nreset,
  input  logic [15:0]      cpu_addr,
  input  logic [7:0]       cpu_data_out,
  input  logic             cpu_rw,
  output logic             cpu_halt,
  output logic [15:0]      bus_addr,
  output logic [7:0]       bus_data_out,
  output logic             bus_rw,
  input  logic [7:0]       bus_data_in,
  output logic             dma_active,
  output dma_state_e       dbg_state
);

  // Handshake: the CPU owns the bus whenever cpu_halt is low; a high cpu_halt
  // means the CPU repeats its current cycle and the bus is driven from here.

  dma_state_e  state;
  logic        parity;    // 0 = get cycle, 1 = put cycle
  logic [7:0]  idx;
  logic [7:0]  page;
  logic [7:0]  dma_buf;

  always_ff @(posedge clock) begin
    if (nreset) begin
      state   <= ST_IDLE;
      parity  <= 1'b0;
      idx     <= 8'h00;
      page    <= 8'h00;
      dma_buf <= 8'h00;
    end else begin
      parity <= ~parity;
      case (state)
        ST_IDLE: begin
          if (is_trigger(cpu_addr, cpu_rw)) begin
            page  <= cpu_data_out;
            state <= ST_PEND;
          end
        end
        ST_PEND: begin
          // The first CPU read is the halt dummy; READ must land on a get cycle.
          if (cpu_rw) begin
            state <= parity ? ST_READ : ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          state <= ST_READ;
        end
        ST_READ: begin
          dma_buf <= bus_data_in;
          state   <= ST_WRITE;
        end
        ST_WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx != 8'hFF) ? ST_READ : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cpu_halt     = 1'b0;
    bus_addr     = cpu_addr;
    bus_data_out = cpu_data_out;
    bus_rw       = cpu_rw;
    case (state)
      ST_PEND: begin
        cpu_halt = cpu_rw;
      end
      ST_ALIGN: begin
        cpu_halt     = 1'b1;
        bus_addr     = cpu_addr;
        bus_data_out = 8'h00;
        bus_rw       = 1'b1;
      end
      ST_READ: begin
        cpu_halt     = 1'b1;
        bus_addr     = {page, idx};
        bus_data_out = 8'h00;
        bus_rw       = 1'b1;
      end
      ST_WRITE: begin
        cpu_halt     = 1'b1;
        bus_addr     = OAMDATA_ADDR;
        bus_data_out = dma_buf;
        bus_rw       = 1'b0;
      end
      default: begin
        cpu_halt = 1'b0;
      end
    endcase
  end

  assign dma_active = is_dma_state(state);
  assign dbg_state  = state;

endmodule
